// File: rtl/vend_pkg.sv
// Shared types for the vending transaction controller: FSM states, coin codes, coin value decode.
package vend_pkg;
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CREDIT   = 2'd1,
        DISPENSE = 2'd2,
        CHANGE   = 2'd3
    } state_t;

    localparam logic [1:0] COIN_5  = 2'b01;
    localparam logic [1:0] COIN_10 = 2'b10;

    // Value in 5-unit coins; 0 marks an invalid code.
    function automatic logic [1:0] coin_units(input logic [1:0] code);
        case (code)
            COIN_5:  return 2'd1;
            COIN_10: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction
endpackage

// File: rtl/vend_txn_controller_if.sv
// Front-panel and driver handshake bundle; slave is the controller, master is the panel/driver side.
interface vend_txn_controller_if #(
    parameter int N_PROD   = 4,
    parameter int CREDIT_W = 4,
    parameter int ID_W     = (N_PROD > 1) ? $clog2(N_PROD) : 1
);
    logic                coin_valid;
    logic [1:0]          in;
    logic                coin_accept;
    logic                coin_reject;
    logic                sel_valid;
    logic [ID_W-1:0]     sel_id;
    logic [N_PROD-1:0]   stock_empty;
    logic                cancel;
    logic                sel_err;
    logic                disp_req;
    logic [ID_W-1:0]     disp_id;
    logic                disp_ack;
    logic                chg_req;
    logic                chg_ack;
    logic [CREDIT_W-1:0] credit;
    logic                busy;

    modport master (
        output coin_valid, in, sel_valid, sel_id, stock_empty, cancel, disp_ack, chg_ack,
        input  coin_accept, coin_reject, sel_err, disp_req, disp_id, chg_req, credit, busy
    );
    modport slave (
        input  coin_valid, in, sel_valid, sel_id, stock_empty, cancel, disp_ack, chg_ack,
        output coin_accept, coin_reject, sel_err, disp_req, disp_id, chg_req, credit, busy
    );
endinterface

// File: rtl/vend_idle_timer.sv
// Idle watchdog: counts enabled, event-free cycles and flags the TIMEOUT-th one.
module vend_idle_timer #(
    parameter int TIMEOUT = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int W = $clog2(TIMEOUT);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst || clear || !enable)
            cnt <= '0;
        else if (cnt != LAST)
            cnt <= cnt + 1'b1;
    end

    assign expire = enable && !clear && (cnt == LAST);
endmodule

// File: rtl/vend_txn_controller.sv
// Vending transaction sequencer: credit keeping, product selection, dispense and change handshakes.
module vend_txn_controller
    import vend_pkg::*;
#(
    parameter int                          N_PROD     = 4,
    parameter int                          CREDIT_W   = 4,
    parameter int                          MAX_CREDIT = 8,
    parameter logic [N_PROD*CREDIT_W-1:0]  PRICES     = {4'd6, 4'd5, 4'd4, 4'd3},
    parameter int                          TIMEOUT    = 1000
) (
    input logic                  clk,
    input logic                  rst,
    vend_txn_controller_if.slave bus
);
    localparam int ID_W = (N_PROD > 1) ? $clog2(N_PROD) : 1;
    localparam logic [CREDIT_W:0] MAX_C = (CREDIT_W + 1)'(MAX_CREDIT);

    state_t              state, state_n;
    logic [CREDIT_W-1:0] credit_n, price;
    logic [CREDIT_W:0]   coin_sum;
    logic [ID_W-1:0]     disp_id_n;
    logic                sel_ok, coin_ok, expire, acc_n, rej_n, err_n;

    vend_idle_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (bus.coin_valid | bus.sel_valid | bus.cancel),
        .enable (state == CREDIT),
        .expire (expire)
    );

    assign price    = PRICES[bus.sel_id*CREDIT_W +: CREDIT_W];
    assign sel_ok   = (int'(bus.sel_id) < N_PROD) && !bus.stock_empty[bus.sel_id] && (bus.credit >= price);
    assign coin_sum = {1'b0, bus.credit} + (CREDIT_W + 1)'(coin_units(bus.in));
    assign coin_ok  = (coin_units(bus.in) != 2'd0) && (coin_sum <= MAX_C);

    always_comb begin
        state_n   = state;
        credit_n  = bus.credit;
        disp_id_n = bus.disp_id;
        acc_n     = 1'b0;
        rej_n     = 1'b0;
        err_n     = 1'b0;
        case (state)
            IDLE, CREDIT: begin
                if (bus.cancel && state == CREDIT) begin
                    state_n = CHANGE;
                    rej_n   = bus.coin_valid;
                end else if (bus.sel_valid && sel_ok) begin
                    // Select is judged on pre-coin credit and takes priority over a same-cycle coin.
                    credit_n  = bus.credit - price;
                    disp_id_n = bus.sel_id;
                    state_n   = DISPENSE;
                    rej_n     = bus.coin_valid;
                end else begin
                    err_n = bus.sel_valid;
                    if (bus.coin_valid) begin
                        if (coin_ok) begin
                            credit_n = coin_sum[CREDIT_W-1:0];
                            acc_n    = 1'b1;
                            state_n  = CREDIT;
                        end else begin
                            rej_n = 1'b1;
                        end
                    end else if (expire) begin
                        state_n = CHANGE;
                    end
                end
            end
            DISPENSE: begin
                rej_n = bus.coin_valid;
                if (bus.disp_ack)
                    state_n = (bus.credit != '0) ? CHANGE : IDLE;
            end
            CHANGE: begin
                rej_n = bus.coin_valid;
                if (bus.chg_ack) begin
                    credit_n = bus.credit - CREDIT_W'(1);
                    if (bus.credit == CREDIT_W'(1))
                        state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= IDLE;
            bus.credit      <= '0;
            bus.disp_id     <= '0;
            bus.disp_req    <= 1'b0;
            bus.chg_req     <= 1'b0;
            bus.busy        <= 1'b0;
            bus.coin_accept <= 1'b0;
            bus.coin_reject <= 1'b0;
            bus.sel_err     <= 1'b0;
        end else begin
            state           <= state_n;
            bus.credit      <= credit_n;
            bus.disp_id     <= disp_id_n;
            bus.disp_req    <= (state_n == DISPENSE);
            bus.chg_req     <= (state_n == CHANGE);
            bus.busy        <= (state_n == DISPENSE) || (state_n == CHANGE);
            bus.coin_accept <= acc_n;
            bus.coin_reject <= rej_n;
            bus.sel_err     <= err_n;
        end
    end

    // Balance must stay within the register's legal range and change is never requested on empty credit.
    always_ff @(posedge clk) begin
        if (rst) begin
            assert ({1'b0, bus.credit} <= MAX_C);
            assert (!(bus.chg_req && bus.credit == '0));
        end
    end
endmodule

// File: tb/tb_vend_txn_controller.sv
// Directed bench for vend_txn_controller: one task per scenario with hand-computed expectations.
module tb_vend_txn_controller;
    import vend_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int failures = 0;

    vend_txn_controller_if #(.N_PROD(4), .CREDIT_W(4)) vif();

    vend_txn_controller #(
        .N_PROD(4), .CREDIT_W(4), .MAX_CREDIT(8),
        .PRICES({4'd6, 4'd5, 4'd4, 4'd3}), .TIMEOUT(20)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (vif)
    );

    always #5 clk = ~clk;

    // {coin_accept, coin_reject, sel_err, disp_req, chg_req, busy, credit}
    function automatic logic [9:0] obs();
        return {vif.coin_accept, vif.coin_reject, vif.sel_err, vif.disp_req,
                vif.chg_req, vif.busy, vif.credit};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        vif.coin_valid = 1'b0;
        vif.sel_valid  = 1'b0;
        vif.cancel     = 1'b0;
        vif.disp_ack   = 1'b0;
        vif.chg_ack    = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic coin(input logic [1:0] code);
        vif.coin_valid = 1'b1;
        vif.in = code;
        tick();
    endtask

    task automatic sel(input logic [1:0] id);
        vif.sel_valid = 1'b1;
        vif.sel_id = id;
        tick();
    endtask

    task automatic drain(output int n);
        n = 0;
        while (vif.chg_req && n < 20) begin
            vif.chg_ack = 1'b1;
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (obs() !== {6'b000000, 4'd0}) begin failures++; $display("FAIL reset_state: got %b want %b", obs(), {6'b000000, 4'd0}); end
        coin(COIN_10); coin(COIN_10); coin(COIN_5); sel(2'd0);
        checks++; if (obs() !== {6'b000101, 4'd2} || vif.disp_id !== 2'd0) begin failures++; $display("FAIL rst_pre_dispense: got %b id %0d want %b id 0", obs(), vif.disp_id, {6'b000101, 4'd2}); end
        do_reset();
        checks++; if (obs() !== {6'b000000, 4'd0}) begin failures++; $display("FAIL rst_mid_dispense: got %b want %b", obs(), {6'b000000, 4'd0}); end
    endtask

    task automatic test_basic();
        int n;
        do_reset();
        coin(COIN_5);
        checks++; if (obs() !== {6'b100000, 4'd1}) begin failures++; $display("FAIL basic_coin1: got %b want %b", obs(), {6'b100000, 4'd1}); end
        coin(COIN_5);
        checks++; if (obs() !== {6'b100000, 4'd2}) begin failures++; $display("FAIL basic_coin2: got %b want %b", obs(), {6'b100000, 4'd2}); end
        coin(COIN_10);
        checks++; if (obs() !== {6'b100000, 4'd4}) begin failures++; $display("FAIL basic_coin3: got %b want %b", obs(), {6'b100000, 4'd4}); end
        sel(2'd0);
        checks++; if (obs() !== {6'b000101, 4'd1} || vif.disp_id !== 2'd0) begin failures++; $display("FAIL basic_sel: got %b id %0d want %b id 0", obs(), vif.disp_id, {6'b000101, 4'd1}); end
        tick();
        checks++; if (obs() !== {6'b000101, 4'd1}) begin failures++; $display("FAIL basic_hold: got %b want %b", obs(), {6'b000101, 4'd1}); end
        vif.disp_ack = 1'b1; tick();
        checks++; if (obs() !== {6'b000011, 4'd1}) begin failures++; $display("FAIL basic_to_change: got %b want %b", obs(), {6'b000011, 4'd1}); end
        drain(n);
        checks++; if (n != 1 || obs() !== {6'b000000, 4'd0}) begin failures++; $display("FAIL basic_change: got acks %0d obs %b want 1 %b", n, obs(), {6'b000000, 4'd0}); end
    endtask

    task automatic test_overflow();
        int n;
        do_reset();
        coin(COIN_10); coin(COIN_10); coin(COIN_10); coin(COIN_5);
        checks++; if (obs() !== {6'b100000, 4'd7}) begin failures++; $display("FAIL ovf_fill7: got %b want %b", obs(), {6'b100000, 4'd7}); end
        coin(COIN_10);
        checks++; if (obs() !== {6'b010000, 4'd7}) begin failures++; $display("FAIL ovf_reject10: got %b want %b", obs(), {6'b010000, 4'd7}); end
        coin(COIN_5);
        checks++; if (obs() !== {6'b100000, 4'd8}) begin failures++; $display("FAIL ovf_accept_max: got %b want %b", obs(), {6'b100000, 4'd8}); end
        coin(2'b11);
        checks++; if (obs() !== {6'b010000, 4'd8}) begin failures++; $display("FAIL ovf_invalid_code: got %b want %b", obs(), {6'b010000, 4'd8}); end
        vif.cancel = 1'b1; tick();
        checks++; if (obs() !== {6'b000011, 4'd8}) begin failures++; $display("FAIL ovf_cancel: got %b want %b", obs(), {6'b000011, 4'd8}); end
        drain(n);
        checks++; if (n != 8 || obs() !== {6'b000000, 4'd0}) begin failures++; $display("FAIL ovf_refund: got acks %0d obs %b want 8 %b", n, obs(), {6'b000000, 4'd0}); end
    endtask

    task automatic test_sel_err();
        do_reset();
        coin(COIN_10); sel(2'd1);
        checks++; if (obs() !== {6'b001000, 4'd2}) begin failures++; $display("FAIL selerr_price: got %b want %b", obs(), {6'b001000, 4'd2}); end
        vif.stock_empty = 4'b0001;
        coin(COIN_10); sel(2'd0);
        checks++; if (obs() !== {6'b001000, 4'd4}) begin failures++; $display("FAIL selerr_stock: got %b want %b", obs(), {6'b001000, 4'd4}); end
        sel(2'd1);
        checks++; if (obs() !== {6'b000101, 4'd0} || vif.disp_id !== 2'd1) begin failures++; $display("FAIL sel_exact_price: got %b id %0d want %b id 1", obs(), vif.disp_id, {6'b000101, 4'd0}); end
        sel(2'd2);
        checks++; if (obs() !== {6'b000101, 4'd0} || vif.disp_id !== 2'd1) begin failures++; $display("FAIL sel_in_dispense: got %b id %0d want %b id 1", obs(), vif.disp_id, {6'b000101, 4'd0}); end
        vif.disp_ack = 1'b1; tick();
        checks++; if (obs() !== {6'b000000, 4'd0}) begin failures++; $display("FAIL dispense_to_idle: got %b want %b", obs(), {6'b000000, 4'd0}); end
        vif.stock_empty = 4'b0000;
    endtask

    task automatic test_cancel();
        int n;
        do_reset();
        vif.cancel = 1'b1; tick();
        checks++; if (obs() !== {6'b000000, 4'd0}) begin failures++; $display("FAIL cancel_idle: got %b want %b", obs(), {6'b000000, 4'd0}); end
        coin(COIN_10); coin(COIN_10); coin(COIN_5);
        vif.cancel = 1'b1; vif.coin_valid = 1'b1; vif.in = COIN_5; vif.sel_valid = 1'b1; vif.sel_id = 2'd0;
        tick();
        checks++; if (obs() !== {6'b010011, 4'd5}) begin failures++; $display("FAIL cancel_wins: got %b want %b", obs(), {6'b010011, 4'd5}); end
        drain(n);
        checks++; if (n != 5 || obs() !== {6'b000000, 4'd0}) begin failures++; $display("FAIL cancel_refund: got acks %0d obs %b want 5 %b", n, obs(), {6'b000000, 4'd0}); end
    endtask

    task automatic test_coin_sel();
        int n;
        do_reset();
        coin(COIN_10); coin(COIN_10);
        vif.coin_valid = 1'b1; vif.in = COIN_5; vif.sel_valid = 1'b1; vif.sel_id = 2'd0;
        tick();
        checks++; if (obs() !== {6'b010101, 4'd1}) begin failures++; $display("FAIL coinsel_ok: got %b want %b", obs(), {6'b010101, 4'd1}); end
        vif.disp_ack = 1'b1; tick();
        drain(n);
        checks++; if (n != 1 || obs() !== {6'b000000, 4'd0}) begin failures++; $display("FAIL coinsel_change: got acks %0d obs %b want 1 %b", n, obs(), {6'b000000, 4'd0}); end
        coin(COIN_10);
        vif.coin_valid = 1'b1; vif.in = COIN_10; vif.sel_valid = 1'b1; vif.sel_id = 2'd1;
        tick();
        checks++; if (obs() !== {6'b101000, 4'd4}) begin failures++; $display("FAIL coinsel_precoin: got %b want %b", obs(), {6'b101000, 4'd4}); end
        vif.cancel = 1'b1; tick();
        drain(n);
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        coin(COIN_10);
        repeat (19) tick();
        checks++; if (obs() !== {6'b000000, 4'd2}) begin failures++; $display("FAIL timeout_early: got %b want %b", obs(), {6'b000000, 4'd2}); end
        tick();
        checks++; if (obs() !== {6'b000011, 4'd2}) begin failures++; $display("FAIL timeout_fire: got %b want %b", obs(), {6'b000011, 4'd2}); end
        coin(COIN_5);
        checks++; if (obs() !== {6'b010011, 4'd2}) begin failures++; $display("FAIL coin_in_change: got %b want %b", obs(), {6'b010011, 4'd2}); end
        drain(n);
        checks++; if (n != 2 || obs() !== {6'b000000, 4'd0}) begin failures++; $display("FAIL timeout_refund: got acks %0d obs %b want 2 %b", n, obs(), {6'b000000, 4'd0}); end
    endtask

    initial begin
        vif.coin_valid  = 1'b0;
        vif.in          = 2'b00;
        vif.sel_valid   = 1'b0;
        vif.sel_id      = 2'd0;
        vif.stock_empty = 4'b0000;
        vif.cancel      = 1'b0;
        vif.disp_ack    = 1'b0;
        vif.chg_ack     = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_sel_err();
        test_cancel();
        test_coin_sel();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
